// File: rtl/bsg_manycore_ruche_x_link_pipe_stage.sv
// Ruche-X link repeater stage: independent fwd/rev 2-entry FIFOs between
// a possibly inverted input link and a possibly inverted output link.

// Two-entry valid/ready FIFO operating on logical (non-inverted) values.
// ready_and_o is registered; v_o/data_o depend only on FIFO state and reset.
module bsg_manycore_ruche_x_link_pipe_fifo #(
  parameter int unsigned width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_and_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_and_i
);

  logic [width_p-1:0] mem_q [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               ready_q, ready_d;
  logic               enq, deq;

  // ready_q holds "not full" for the state being entered; it is set during
  // reset so the first cycle after release already advertises space, while
  // the reset gate below still forces the port low during reset itself.
  assign ready_and_o = ready_q & ~reset_i;
  assign v_o         = (count_q != 2'd0) & ~reset_i;
  // Empty or in-reset outputs a defined zero so data_o is never X.
  assign data_o      = v_o ? mem_q[rd_ptr_q] : '0;

  assign enq = v_i & ready_and_o;
  assign deq = v_o & ready_and_i;

  // Next-state pointer/count/ready computation.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q ^ enq;
    rd_ptr_d = rd_ptr_q ^ deq;
    if (enq && !deq) begin
      count_d = count_q + 2'd1;
    end else if (deq && !enq) begin
      count_d = count_q - 2'd1;
    end
    ready_d = (count_d != 2'd2);
  end

  // Control state register with synchronous flush.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
    end
  end

  // Storage write; contents need no reset because data_o is gated by v_o.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

`ifndef SYNTHESIS
  logic               hold_q;
  logic [width_p-1:0] data_prev_q;

  // Simulation checks: known input valid, and output held stable under stall.
  always_ff @(posedge clk_i) begin
    hold_q      <= ~reset_i & v_o & ~ready_and_i;
    data_prev_q <= data_o;
    if (!reset_i && $isunknown(v_i)) begin
      $error("ruche link fifo: v_i is X/Z outside reset");
    end
    if (!reset_i && hold_q && (!v_o || (data_o != data_prev_q))) begin
      $error("ruche link fifo: output changed while stalled");
    end
  end
`endif

endmodule

// Stage top: de-invert input side, buffer each channel, re-invert output side.
module bsg_manycore_ruche_x_link_pipe_stage #(
  parameter int unsigned addr_width_p   = 28,
  parameter int unsigned data_width_p   = 32,
  parameter int unsigned x_cord_width_p = 7,
  parameter int unsigned y_cord_width_p = 7,
  parameter bit          invert_in_p    = 1'b0,
  parameter bit          invert_out_p   = 1'b0,
  // Request packet: op(2) + reg_id(5) + op_ex mask(data/8) + addr + payload + src/dst coords.
  localparam int unsigned fwd_width_lp  = 2 + 5 + (data_width_p >> 3) + addr_width_p
                                          + data_width_p + 2 * (x_cord_width_p + y_cord_width_p),
  // Return packet: type(3) + payload + reg_id(5) + dst coords.
  localparam int unsigned rev_width_lp  = 3 + data_width_p + 5 + x_cord_width_p + y_cord_width_p
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic                    fwd_v_i,
  input  logic [fwd_width_lp-1:0] fwd_data_i,
  output logic                    fwd_ready_and_o,
  output logic                    fwd_v_o,
  output logic [fwd_width_lp-1:0] fwd_data_o,
  input  logic                    fwd_ready_and_i,

  input  logic                    rev_v_i,
  input  logic [rev_width_lp-1:0] rev_data_i,
  output logic                    rev_ready_and_o,
  output logic                    rev_v_o,
  output logic [rev_width_lp-1:0] rev_data_o,
  input  logic                    rev_ready_and_i
);

  localparam logic [fwd_width_lp-1:0] fwd_in_mask_lp  = {fwd_width_lp{invert_in_p}};
  localparam logic [fwd_width_lp-1:0] fwd_out_mask_lp = {fwd_width_lp{invert_out_p}};
  localparam logic [rev_width_lp-1:0] rev_in_mask_lp  = {rev_width_lp{invert_in_p}};
  localparam logic [rev_width_lp-1:0] rev_out_mask_lp = {rev_width_lp{invert_out_p}};

  logic                    fwd_v_li, fwd_ready_lo, fwd_v_lo, fwd_ready_li;
  logic [fwd_width_lp-1:0] fwd_data_li, fwd_data_lo;
  logic                    rev_v_li, rev_ready_lo, rev_v_lo, rev_ready_li;
  logic [rev_width_lp-1:0] rev_data_li, rev_data_lo;

  assign fwd_v_li        = fwd_v_i ^ invert_in_p;
  assign fwd_data_li     = fwd_data_i ^ fwd_in_mask_lp;
  assign fwd_ready_and_o = fwd_ready_lo ^ invert_in_p;
  assign fwd_v_o         = fwd_v_lo ^ invert_out_p;
  assign fwd_data_o      = fwd_data_lo ^ fwd_out_mask_lp;
  assign fwd_ready_li    = fwd_ready_and_i ^ invert_out_p;

  assign rev_v_li        = rev_v_i ^ invert_in_p;
  assign rev_data_li     = rev_data_i ^ rev_in_mask_lp;
  assign rev_ready_and_o = rev_ready_lo ^ invert_in_p;
  assign rev_v_o         = rev_v_lo ^ invert_out_p;
  assign rev_data_o      = rev_data_lo ^ rev_out_mask_lp;
  assign rev_ready_li    = rev_ready_and_i ^ invert_out_p;

  bsg_manycore_ruche_x_link_pipe_fifo #(
    .width_p(fwd_width_lp)
  ) fwd_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (fwd_v_li),
    .data_i     (fwd_data_li),
    .ready_and_o(fwd_ready_lo),
    .v_o        (fwd_v_lo),
    .data_o     (fwd_data_lo),
    .ready_and_i(fwd_ready_li)
  );

  bsg_manycore_ruche_x_link_pipe_fifo #(
    .width_p(rev_width_lp)
  ) rev_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (rev_v_li),
    .data_i     (rev_data_li),
    .ready_and_o(rev_ready_lo),
    .v_o        (rev_v_lo),
    .data_o     (rev_data_lo),
    .ready_and_i(rev_ready_li)
  );

endmodule

// File: tb/tb_bsg_manycore_ruche_x_link_pipe_stage.sv
// Bench for the ruche-X link pipe stage: two instances (in-inverted only, and
// both sides inverted) driven with identical logical stimulus and checked
// against a queue-based link model plus directed literal expectations.
module tb_bsg_manycore_ruche_x_link_pipe_stage;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned XW = 2;
  localparam int unsigned YW = 2;
  localparam int unsigned FW = 2 + 5 + (DW >> 3) + AW + DW + 2 * (XW + YW);
  localparam int unsigned RW = 3 + DW + 5 + XW + YW;
  localparam bit INA = 1'b1, OUTA = 1'b0;
  localparam bit INB = 1'b1, OUTB = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Logical stimulus shared by both instances.
  logic          rst = 1'b1;
  logic          fv = 1'b0, fr = 1'b1, rv = 1'b0, rr = 1'b1;
  logic [FW-1:0] fd = '0;
  logic [RW-1:0] rd = '0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  logic          a_fwd_v_i, a_fwd_ready_and_o, a_fwd_v_o, a_fwd_ready_and_i;
  logic [FW-1:0] a_fwd_data_i, a_fwd_data_o;
  logic          a_rev_v_i, a_rev_ready_and_o, a_rev_v_o, a_rev_ready_and_i;
  logic [RW-1:0] a_rev_data_i, a_rev_data_o;
  logic          b_fwd_v_i, b_fwd_ready_and_o, b_fwd_v_o, b_fwd_ready_and_i;
  logic [FW-1:0] b_fwd_data_i, b_fwd_data_o;
  logic          b_rev_v_i, b_rev_ready_and_o, b_rev_v_o, b_rev_ready_and_i;
  logic [RW-1:0] b_rev_data_i, b_rev_data_o;

  assign a_fwd_v_i         = fv ^ INA;
  assign a_fwd_data_i      = fd ^ {FW{INA}};
  assign a_fwd_ready_and_i = fr ^ OUTA;
  assign a_rev_v_i         = rv ^ INA;
  assign a_rev_data_i      = rd ^ {RW{INA}};
  assign a_rev_ready_and_i = rr ^ OUTA;
  assign b_fwd_v_i         = fv ^ INB;
  assign b_fwd_data_i      = fd ^ {FW{INB}};
  assign b_fwd_ready_and_i = fr ^ OUTB;
  assign b_rev_v_i         = rv ^ INB;
  assign b_rev_data_i      = rd ^ {RW{INB}};
  assign b_rev_ready_and_i = rr ^ OUTB;

  bsg_manycore_ruche_x_link_pipe_stage #(
    .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .invert_in_p(INA), .invert_out_p(OUTA)
  ) dut_a (
    .clk_i(clk), .reset_i(rst),
    .fwd_v_i(a_fwd_v_i), .fwd_data_i(a_fwd_data_i), .fwd_ready_and_o(a_fwd_ready_and_o),
    .fwd_v_o(a_fwd_v_o), .fwd_data_o(a_fwd_data_o), .fwd_ready_and_i(a_fwd_ready_and_i),
    .rev_v_i(a_rev_v_i), .rev_data_i(a_rev_data_i), .rev_ready_and_o(a_rev_ready_and_o),
    .rev_v_o(a_rev_v_o), .rev_data_o(a_rev_data_o), .rev_ready_and_i(a_rev_ready_and_i)
  );

  bsg_manycore_ruche_x_link_pipe_stage #(
    .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .invert_in_p(INB), .invert_out_p(OUTB)
  ) dut_b (
    .clk_i(clk), .reset_i(rst),
    .fwd_v_i(b_fwd_v_i), .fwd_data_i(b_fwd_data_i), .fwd_ready_and_o(b_fwd_ready_and_o),
    .fwd_v_o(b_fwd_v_o), .fwd_data_o(b_fwd_data_o), .fwd_ready_and_i(b_fwd_ready_and_i),
    .rev_v_i(b_rev_v_i), .rev_data_i(b_rev_data_i), .rev_ready_and_o(b_rev_ready_and_o),
    .rev_v_o(b_rev_v_o), .rev_data_o(b_rev_data_o), .rev_ready_and_i(b_rev_ready_and_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Link model: each channel is a queue of at most two logical packets.
  logic [FW-1:0] fq[$];
  logic [RW-1:0] rq[$];

  always @(posedge clk) begin : model
    bit take, give;
    cyc <= cyc + 1;
    if (rst) begin
      fq.delete();
      rq.delete();
    end else begin
      take = fv && (fq.size() < 2);
      give = (fq.size() > 0) && fr;
      if (give) void'(fq.pop_front());
      if (take) fq.push_back(fd);
      take = rv && (rq.size() < 2);
      give = (rq.size() > 0) && rr;
      if (give) void'(rq.pop_front());
      if (take) rq.push_back(rd);
    end
  end

  // Per-cycle comparison of every wire output of both instances.
  always @(negedge clk) begin : compare
    logic          mfv, mfr, mrv, mrr;
    logic [FW-1:0] mfd;
    logic [RW-1:0] mrd;
    mfv = !rst && (fq.size() > 0);
    mfr = !rst && (fq.size() < 2);
    mfd = mfv ? fq[0] : '0;
    mrv = !rst && (rq.size() > 0);
    mrr = !rst && (rq.size() < 2);
    mrd = mrv ? rq[0] : '0;
    chk("a_fwd_v_o", 32'(a_fwd_v_o), 32'(mfv ^ OUTA));
    chk("a_fwd_data_o", 32'(a_fwd_data_o), 32'(mfd ^ {FW{OUTA}}));
    chk("a_fwd_ready_and_o", 32'(a_fwd_ready_and_o), 32'(mfr ^ INA));
    chk("a_rev_v_o", 32'(a_rev_v_o), 32'(mrv ^ OUTA));
    chk("a_rev_data_o", 32'(a_rev_data_o), 32'(mrd ^ {RW{OUTA}}));
    chk("a_rev_ready_and_o", 32'(a_rev_ready_and_o), 32'(mrr ^ INA));
    chk("b_fwd_v_o", 32'(b_fwd_v_o), 32'(mfv ^ OUTB));
    chk("b_fwd_data_o", 32'(b_fwd_data_o), 32'(mfd ^ {FW{OUTB}}));
    chk("b_fwd_ready_and_o", 32'(b_fwd_ready_and_o), 32'(mfr ^ INB));
    chk("b_rev_v_o", 32'(b_rev_v_o), 32'(mrv ^ OUTB));
    chk("b_rev_data_o", 32'(b_rev_data_o), 32'(mrd ^ {RW{OUTB}}));
    chk("b_rev_ready_and_o", 32'(b_rev_ready_and_o), 32'(mrr ^ INB));
  end

  // Record packets actually delivered by the DUTs, with the cycle they left.
  logic [FW-1:0] fseen[$];
  int unsigned   fstamp[$];
  logic [RW-1:0] rseen[$];
  int unsigned   b_fcount = 0;

  always @(negedge clk) begin
    if (!rst && (a_fwd_v_o ^ OUTA) && fr) begin
      fseen.push_back(a_fwd_data_o ^ {FW{OUTA}});
      fstamp.push_back(cyc);
    end
    if (!rst && (a_rev_v_o ^ OUTA) && rr) rseen.push_back(a_rev_data_o ^ {RW{OUTA}});
    if (!rst && (b_fwd_v_o ^ OUTB) && fr) b_fcount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_seen();
    fseen.delete();
    fstamp.delete();
    rseen.delete();
    b_fcount = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned s;
    // Reset: wires reflect inverted idle levels.
    tick();
    tick();
    @(negedge clk);
    chk("rst_a_fwd_v_wire", 32'(a_fwd_v_o), 32'd0);
    chk("rst_a_fwd_ready_wire", 32'(a_fwd_ready_and_o), 32'd1);
    chk("rst_b_fwd_data_wire", 32'(b_fwd_data_o), 32'h0fff_ffff);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_a_fwd_ready_wire", 32'(a_fwd_ready_and_o), 32'd0);
    tick();

    // Streaming 16 packets with downstream always ready.
    clear_seen();
    s = cyc;
    for (int k = 0; k < 16; k++) begin
      fv = 1'b1;
      fd = FW'(k);
      tick();
    end
    fv = 1'b0;
    repeat (3) tick();
    chk("stream_count", fseen.size(), 32'd16);
    chk("stream_b_count", b_fcount, 32'd16);
    for (int k = 0; k < 16 && k < fseen.size(); k++) begin
      chk("stream_data", 32'(fseen[k]), 32'(k));
      chk("stream_cycle", fstamp[k], s + 32'(k) + 32'd1);
    end

    // Backpressure: two accepted, third held until space frees.
    clear_seen();
    fr = 1'b0;
    fv = 1'b1;
    fd = FW'(100);
    tick();
    fd = FW'(101);
    tick();
    fd = FW'(102);
    @(negedge clk);
    chk("bp_ready_logical", 32'(a_fwd_ready_and_o ^ INA), 32'd0);
    chk("bp_head_data", 32'(a_fwd_data_o ^ {FW{OUTA}}), 32'd100);
    tick();
    tick();
    fr = 1'b1;
    s = cyc;
    tick();
    tick();
    fv = 1'b0;
    repeat (3) tick();
    chk("bp_count", fseen.size(), 32'd3);
    for (int k = 0; k < 3 && k < fseen.size(); k++) begin
      chk("bp_data", 32'(fseen[k]), 32'd100 + 32'(k));
      chk("bp_cycle", fstamp[k], s + 32'(k));
    end

    // Stall with one packet buffered: output must hold.
    clear_seen();
    fr = 1'b0;
    fv = 1'b1;
    fd = FW'(50);
    tick();
    fv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_hold_data", 32'(a_fwd_data_o ^ {FW{OUTA}}), 32'd50);
      tick();
    end
    fr = 1'b1;
    tick();
    tick();
    chk("stall_release_count", fseen.size(), 32'd1);

    // Channel independence: fwd blocked, rev streams.
    clear_seen();
    fr = 1'b0;
    rr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fv = (i < 2);
      fd = FW'(300 + i);
      rv = (i < 10);
      rd = RW'(500 + i);
      tick();
    end
    fv = 1'b0;
    rv = 1'b0;
    tick();
    chk("indep_rev_count", rseen.size(), 32'd10);
    for (int i = 0; i < 10 && i < rseen.size(); i++) begin
      chk("indep_rev_data", 32'(rseen[i]), 32'd500 + 32'(i));
    end
    chk("indep_fwd_none", fseen.size(), 32'd0);
    @(negedge clk);
    chk("indep_fwd_full", 32'(a_fwd_ready_and_o ^ INA), 32'd0);
    fr = 1'b1;
    repeat (4) tick();
    chk("indep_fwd_count", fseen.size(), 32'd2);
    for (int i = 0; i < 2 && i < fseen.size(); i++) begin
      chk("indep_fwd_data", 32'(fseen[i]), 32'd300 + 32'(i));
    end

    // Reset with two packets buffered: nothing emerges afterwards.
    clear_seen();
    fr = 1'b0;
    fv = 1'b1;
    fd = FW'(400);
    tick();
    fd = FW'(401);
    tick();
    fv = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    fr = 1'b1;
    repeat (4) tick();
    chk("rst_drop_count", fseen.size(), 32'd0);
    @(negedge clk);
    chk("rst_drop_v_logical", 32'(a_fwd_v_o ^ OUTA), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
